// File: rtl/rfa_wrr_arbiter.sv
// Weighted round-robin arbiter for register-file read ports. A winner may keep the
// port for up to its weight in consecutive grants. Stall freezes all arbitration state.
module rfa_wrr_arbiter #(
    parameter int NUM_REQ  = 16,
    parameter int IDX_W    = 4,
    parameter int WEIGHT_W = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*WEIGHT_W-1:0] weight,
    input  logic                        stall,
    output logic [NUM_REQ-1:0]          grant,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        grant_valid,
    output logic                        burst_last
);

    localparam int SLOTS = 2 ** IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } mode_e;

    mode_e               mode_q, mode_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [WEIGHT_W-1:0] rem_q, rem_d;

    // Requests and weights padded to the full index space so every IDX_W-bit index is legal.
    logic [SLOTS-1:0]    req_ext;
    logic [WEIGHT_W-1:0] weight_arr [SLOTS];

    assign req_ext = SLOTS'(req);

    for (genvar g = 0; g < SLOTS; g++) begin : g_weight
        if (g < NUM_REQ) begin : g_live
            assign weight_arr[g] = weight[g*WEIGHT_W +: WEIGHT_W];
        end else begin : g_pad
            assign weight_arr[g] = '0;
        end
    end

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) >= NUM_REQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Wrap happens at NUM_REQ, not at the index width.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    logic [IDX_W-1:0]    start_idx;
    logic [IDX_W-1:0]    win_idx;
    logic                found;
    logic [WEIGHT_W-1:0] win_budget;
    logic                hold;
    logic                active;

    // NOTE: scanning offsets from the far end down lets the nearest requester overwrite the rest.
    always_comb begin
        start_idx = (mode_q == BURST) ? next_idx(owner_q) : ptr_q;
        found     = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_ext[wrap_add(start_idx, k)]) begin
                found   = 1'b1;
                win_idx = wrap_add(start_idx, k);
            end
        end
    end

    assign win_budget = (weight_arr[win_idx] == '0) ? WEIGHT_W'(1) : weight_arr[win_idx];
    assign hold       = (mode_q == BURST) && req_ext[owner_q];
    assign active     = !rst && !stall;

    // NOTE: every output and next-state term gets a default first so no latch is inferred.
    always_comb begin
        mode_d      = mode_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        rem_d       = rem_q;
        grant_valid = 1'b0;
        grant_idx   = '0;
        burst_last  = 1'b0;
        if (active) begin
            if (hold) begin
                grant_valid = 1'b1;
                grant_idx   = owner_q;
                if (rem_q == WEIGHT_W'(1)) begin
                    burst_last = 1'b1;
                    mode_d     = IDLE;
                    ptr_d      = next_idx(owner_q);
                end else begin
                    rem_d = rem_q - 1'b1;
                end
            end else if (found) begin
                grant_valid = 1'b1;
                grant_idx   = win_idx;
                if (win_budget == WEIGHT_W'(1)) begin
                    burst_last = 1'b1;
                    mode_d     = IDLE;
                    ptr_d      = next_idx(win_idx);
                end else begin
                    mode_d  = BURST;
                    owner_d = win_idx;
                    rem_d   = win_budget - 1'b1;
                end
            end else if (mode_q == BURST) begin
                // Owner dropped out and nobody else is asking: close the turn.
                mode_d = IDLE;
                ptr_d  = next_idx(owner_q);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = grant_valid && (grant_idx == IDX_W'(i));
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            rem_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            rem_q   <= rem_d;
        end
    end

endmodule
